fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Owns the program counter and sequences the instruction fetch port of the core. Each cycle it drives the synchronous-read BIOS and IMEM address ports. It steers the returned word by memory region and presents one instruction per cycle, with its PC, to the decode stage. It also handles boot, back-pressure (stall) and control-flow redirects, and injects NOP bubbles (`32'h0000_0013`) wherever no valid instruction exists.

## Interface
- `RESET_PC`, `32'h4000_0000`, first fetch address after reset (BIOS entry).
- `NOP_INST`, `32'h0000_0013`, bubble instruction (`addi x0,x0,0`).
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  decode cannot accept; hold presented instruction.
- `redirect_valid`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  32  target; bits [1:0] ignored (treated as 0).
- `bios_addr`  out  12  BIOS word address.
- `bios_dout`  in  32  BIOS read data, one cycle after address.
- `imem_addr`  out  14  IMEM word address.
- `imem_dout`  in  32  IMEM read data, one cycle after address.
- `fetch_pc`  out  32  PC of `inst`.
- `inst`  out  32  instruction to decode.
- `inst_valid`  out  1  `inst` is a real, non-squashed instruction.

## Operation
- Internal state: `pc_q` (address issued last cycle), `state` ∈ {BOOT, RUN}.
- Next address `addr_n`:
  - `rst`: don't-care.
  - BOOT: `RESET_PC`.
  - `redirect_valid`: `{redirect_pc[31:2],2'b00}`.
  - `stall`: `pc_q`.
  - Otherwise: `pc_q + 4`. Wraps modulo 2^32.
- `bios_addr = addr_n[13:2]`; `imem_addr = addr_n[15:2]`. Both are driven every cycle.
- Region select: `pc_q[30]=1` → `bios_dout`, else `imem_dout`.
- `fetch_pc = pc_q`.
- `inst` / `inst_valid`:
  - BOOT: `NOP_INST` / 0.
  - RUN with `redirect_valid`: `NOP_INST` / 0. This is a combinational squash of the wrong-path word.
  - RUN otherwise: selected word / 1.
- Transitions:
  - `rst` → BOOT.
  - BOOT → RUN unconditionally on the next edge; `stall` and `redirect_valid` are ignored in BOOT.
  - RUN stays RUN.
- Priority: `rst` > `redirect_valid` > `stall`. When redirect and stall are both asserted, the redirect target is issued and the stall is dropped for that cycle.
- Stall hold: re-issuing `pc_q` makes the memory return the same word, so `inst` stays stable for the whole stall.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `state=BOOT`, `pc_q=RESET_PC`, `fetch_pc=RESET_PC`.
  - `inst=NOP_INST`, `inst_valid=0`.
  - `bios_addr=RESET_PC[13:2]`.
- Fetch latency: address issued in cycle N → instruction visible in cycle N+1.
- Redirect penalty:
  - Cycle N, redirect asserted: one bubble.
  - Cycle N+1: target instruction presented with `inst_valid=1`.
- Throughput: one instruction per cycle when `stall=0`.
- Combinational paths:
  - `redirect_valid`/`redirect_pc`/`stall` → address outputs.
  - `redirect_valid` → `inst`/`inst_valid`.
  - Memory dout → `inst`.
- Reset mid-stall or mid-redirect discards all state; the next cycle is BOOT.

## Configuration
- `FETCH_SKID_EN` defined:
  - A 32-bit hold register captures the presented word on the first stall cycle.
  - `inst` is sourced from the hold register until `stall` drops.
  - Held `inst` is immune to IMEM writes during the stall.
  - Address behaviour is unchanged.
- Undefined: no hold register; the stall relies on re-reading `pc_q`.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INST` and `RESET_PC` defaults.
  - `BIOS_REGION_BIT=30`.
  - The `fetch_state_t` enum {BOOT, RUN}.
- One sub-module, `fetch_inst_select`. It performs the combinational region mux plus the squash/NOP mux, and includes the skid register when `FETCH_SKID_EN` is defined.

## Test plan
- Reset release, BIOS word 0 = `32'h0000_0093` → cycle 0: `bios_addr=0`, `inst_valid=0`; cycle 1: `inst=32'h93`, `fetch_pc=32'h4000_0000`.
- 4 free-running cycles after boot → `bios_addr` 1,2,3,4 in sequence; each `inst` matches the model BIOS word with `inst_valid=1`.
- `redirect_valid=1`, `redirect_pc=32'h1000_0012` → same cycle: `inst=32'h13`, `inst_valid=0`, `imem_addr=4`; next cycle: IMEM word 4 presented with `fetch_pc=32'h1000_0010`.
- `stall` held 3 cycles at `fetch_pc=32'h4000_0008` → `bios_addr` constant at 2 and `inst` constant; release → `fetch_pc=32'h4000_000C`.
- `stall` and `redirect_valid` together to `32'h4000_0100` → redirect wins; next cycle `fetch_pc=32'h4000_0100`, `inst_valid=1`.
- `FETCH_SKID_EN` build: during stall, IMEM word at `pc_q` changed by the testbench → `inst` keeps its original value until `stall` drops.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the fetch sequencer slice.
// Optional skid hold register is enabled by defining FETCH_SKID_EN.
package fetch_pkg;

    localparam logic [31:0] RESET_PC        = 32'h4000_0000;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    localparam int          BIOS_REGION_BIT = 30;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch port bundle: decode-side controls, BIOS/IMEM read ports and the decode output.
// Optional skid hold register is enabled by defining FETCH_SKID_EN.
interface fetch_sequencer_if;
    // Flow control: there is no valid/ready pair. inst/inst_valid are presented every
    // cycle; while stall is high decode has not taken them and they are held unchanged,
    // and an instruction is consumed on each cycle where inst_valid=1 and stall=0.
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] fetch_pc;
    logic [31:0] inst;
    logic        inst_valid;

    modport master (
        input  stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
        output bios_addr, imem_addr, fetch_pc, inst, inst_valid
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, bios_dout, imem_dout,
        input  bios_addr, imem_addr, fetch_pc, inst, inst_valid
    );
endinterface

// File: rtl/fetch_sequencer_inst_select.sv
// Region mux and squash/NOP mux for the presented instruction.
// With FETCH_SKID_EN defined, a hold register freezes the word across a stall.
module fetch_inst_select
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic        i_squash,
    input  logic        i_stall,
    input  logic        i_bios_sel,
    input  logic [31:0] i_bios_dout,
    input  logic [31:0] i_imem_dout,
    output logic [31:0] o_inst,
    output logic        o_inst_valid
);

    logic [31:0] w_word;
    logic [31:0] w_presented;
    logic        w_valid;

    assign w_word  = i_bios_sel ? i_bios_dout : i_imem_dout;
    assign w_valid = i_run && !i_squash;

`ifdef FETCH_SKID_EN
    logic [31:0] r_hold;
    logic        r_holding;

    // r_hold tracks the live word until a stall begins, then freezes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_holding <= 1'b0;
            r_hold    <= NOP_INST;
        end else begin
            r_holding <= i_run && i_stall && !i_squash;
            if (!r_holding) begin
                r_hold <= w_word;
            end
        end
    end

    assign w_presented = (r_holding && i_stall) ? r_hold : w_word;
`else
    logic w_unused_skid;
    assign w_unused_skid = ^{i_clk, i_rst, i_stall};
    assign w_presented   = w_word;
`endif

    assign o_inst       = w_valid ? w_presented : NOP_INST;
    assign o_inst_valid = w_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencing for the BIOS/IMEM synchronous-read ports.
// Optional skid hold register is enabled by defining FETCH_SKID_EN.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus,
    output fetch_state_t      o_dbg_state
);

    localparam logic [0:0] S_BOOT = BOOT;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] w_addr_n;
    logic [31:0] w_target;
    logic        w_run;
    logic        w_unused_lsb;

    assign w_run        = (r_state == S_RUN);
    assign w_target     = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_lsb = ^bus.redirect_pc[1:0];

    // Redirect outranks stall; BOOT ignores both and always issues the reset vector.
    always_comb begin
        w_addr_n = next_seq_pc(r_pc);
        if (!w_run) begin
            w_addr_n = RESET_PC;
        end else if (bus.redirect_valid) begin
            w_addr_n = w_target;
        end else if (bus.stall) begin
            w_addr_n = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= S_RUN;
            r_pc    <= w_addr_n;
        end
    end

    assign bus.bios_addr = w_addr_n[13:2];
    assign bus.imem_addr = w_addr_n[15:2];
    assign bus.fetch_pc  = r_pc;
    assign o_dbg_state   = fetch_state_t'(r_state);

    fetch_inst_select u_inst_select (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (w_run),
        .i_squash     (bus.redirect_valid),
        .i_stall      (bus.stall),
        .i_bios_sel   (r_pc[BIOS_REGION_BIT]),
        .i_bios_dout  (bus.bios_dout),
        .i_imem_dout  (bus.imem_dout),
        .o_inst       (bus.inst),
        .o_inst_valid (bus.inst_valid)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with synchronous-read BIOS/IMEM models.
// Define FETCH_SKID_EN to check the stall hold register behaviour.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    fetch_state_t dbg_state;
    fetch_sequencer_if bus();

    logic [31:0] bios_mem [4096];
    logic [31:0] imem_mem [16384];
    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.bios_dout <= bios_mem[bus.bios_addr];
        bus.imem_dout <= imem_mem[bus.imem_addr];
    end

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return pc[30] ? bios_mem[pc[13:2]] : imem_mem[pc[15:2]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        step();
        step();
        rst = 1'b0;
        settle();
        n_vec++; if (dbg_state !== BOOT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, BOOT); end
        n_vec++; if (bus.bios_addr !== 12'h000) begin n_err++; $display("FAIL reset_bios_addr: got %h want 000", bus.bios_addr); end
        n_vec++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
        n_vec++; if (bus.inst !== 32'h0000_0013) begin n_err++; $display("FAIL reset_inst: got %h want 00000013", bus.inst); end
        n_vec++; if (bus.fetch_pc !== 32'h4000_0000) begin n_err++; $display("FAIL reset_pc: got %h want 40000000", bus.fetch_pc); end
        step();
        n_vec++; if (bus.inst !== 32'h0000_0093) begin n_err++; $display("FAIL boot_inst: got %h want 00000093", bus.inst); end
        n_vec++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL boot_valid: got %b want 1", bus.inst_valid); end
        n_vec++; if (bus.fetch_pc !== 32'h4000_0000) begin n_err++; $display("FAIL boot_pc: got %h want 40000000", bus.fetch_pc); end
    endtask

    task automatic test_free_run();
        logic [31:0] e;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (bus.bios_addr !== 12'(i)) begin n_err++; $display("FAIL run_bios_addr: got %h want %h", bus.bios_addr, 12'(i)); end
            exp_q.push_back(bios_mem[i]);
            step();
            e = exp_q.pop_front();
            n_vec++; if (bus.inst !== e || bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL run_inst: got %h/%b want %h/1", bus.inst, bus.inst_valid, e); end
            n_vec++; if (bus.fetch_pc !== 32'h4000_0000 + 32'(4 * i)) begin n_err++; $display("FAIL run_pc: got %h want %h", bus.fetch_pc, 32'h4000_0000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h1000_0012;
        settle();
        n_vec++; if (bus.inst !== 32'h13 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_squash: got %h/%b want 00000013/0", bus.inst, bus.inst_valid); end
        n_vec++; if (bus.imem_addr !== 14'd4) begin n_err++; $display("FAIL redir_imem_addr: got %h want 0004", bus.imem_addr); end
        exp_q.push_back(imem_mem[4]);
        step();
        bus.redirect_valid = 1'b0;
        settle();
        e = exp_q.pop_front();
        n_vec++; if (bus.inst !== e || bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL redir_target: got %h/%b want %h/1", bus.inst, bus.inst_valid, e); end
        n_vec++; if (bus.fetch_pc !== 32'h1000_0010) begin n_err++; $display("FAIL redir_pc: got %h want 10000010", bus.fetch_pc); end
    endtask

    task automatic test_stall();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h4000_0008;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b1;
        settle();
        n_vec++; if (bus.bios_addr !== 12'd2) begin n_err++; $display("FAIL stall_addr0: got %h want 002", bus.bios_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (bus.bios_addr !== 12'd2) begin n_err++; $display("FAIL stall_addr: got %h want 002", bus.bios_addr); end
            n_vec++; if (bus.inst !== bios_mem[2] || bus.fetch_pc !== 32'h4000_0008) begin n_err++; $display("FAIL stall_hold: got %h@%h want %h@40000008", bus.inst, bus.fetch_pc, bios_mem[2]); end
        end
        bus.stall = 1'b0;
        settle();
        n_vec++; if (bus.bios_addr !== 12'd3) begin n_err++; $display("FAIL unstall_addr: got %h want 003", bus.bios_addr); end
        step();
        n_vec++; if (bus.fetch_pc !== 32'h4000_000C || bus.inst !== bios_mem[3]) begin n_err++; $display("FAIL unstall_next: got %h@%h want %h@4000000c", bus.inst, bus.fetch_pc, bios_mem[3]); end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h4000_0100;
        settle();
        n_vec++; if (bus.bios_addr !== 12'h040 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rs_addr: got %h/%b want 040/0", bus.bios_addr, bus.inst_valid); end
        step();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        settle();
        n_vec++; if (bus.fetch_pc !== 32'h4000_0100 || bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL rs_target: got %h/%b want 40000100/1", bus.fetch_pc, bus.inst_valid); end
        n_vec++; if (bus.inst !== bios_mem[64]) begin n_err++; $display("FAIL rs_inst: got %h want %h", bus.inst, bios_mem[64]); end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        settle();
        n_vec++; if (bus.fetch_pc !== 32'hFFFF_FFFC || bus.inst !== bios_mem[4095]) begin n_err++; $display("FAIL wrap_top: got %h@%h want %h@fffffffc", bus.inst, bus.fetch_pc, bios_mem[4095]); end
        n_vec++; if (bus.imem_addr !== 14'd0) begin n_err++; $display("FAIL wrap_addr: got %h want 0000", bus.imem_addr); end
        step();
        n_vec++; if (bus.fetch_pc !== 32'h0 || bus.inst !== imem_mem[0]) begin n_err++; $display("FAIL wrap_zero: got %h@%h want %h@00000000", bus.inst, bus.fetch_pc, imem_mem[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model_pc;
        logic [31:0] nxt;
        logic [31:0] tgt;
        logic [31:0] e;
        logic        redir;
        logic        stl;
        model_pc = 32'h0;
        exp_q.push_back(exp_word(model_pc));
        for (int i = 0; i < 40; i++) begin
            redir = ($urandom_range(0, 3) == 0);
            stl   = ($urandom_range(0, 3) == 0);
            tgt   = {1'b0, 1'($urandom_range(0, 1)), 14'h0, 16'($urandom)};
            bus.redirect_valid = redir;
            bus.stall = stl;
            bus.redirect_pc = tgt;
            settle();
            e = exp_q.pop_front();
            if (redir) nxt = {tgt[31:2], 2'b00};
            else if (stl) nxt = model_pc;
            else nxt = model_pc + 32'd4;
            n_vec++; if (bus.fetch_pc !== model_pc) begin n_err++; $display("FAIL b2b_pc: got %h want %h", bus.fetch_pc, model_pc); end
            n_vec++; if (bus.inst_valid !== !redir || bus.inst !== (redir ? NOP_INST : e)) begin n_err++; $display("FAIL b2b_inst: got %h/%b want %h/%b", bus.inst, bus.inst_valid, redir ? NOP_INST : e, !redir); end
            n_vec++; if (bus.bios_addr !== nxt[13:2] || bus.imem_addr !== nxt[15:2]) begin n_err++; $display("FAIL b2b_addr: got %h/%h want %h/%h", bus.bios_addr, bus.imem_addr, nxt[13:2], nxt[15:2]); end
            exp_q.push_back(exp_word(nxt));
            step();
            model_pc = nxt;
        end
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        settle();
        e = exp_q.pop_front();
        n_vec++; if (bus.inst !== e || bus.fetch_pc !== model_pc) begin n_err++; $display("FAIL b2b_last: got %h@%h want %h@%h", bus.inst, bus.fetch_pc, e, model_pc); end
    endtask

    task automatic test_stall_mem_write();
        logic [31:0] orig;
        logic [31:0] upd;
        logic [31:0] held;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b1;
        settle();
        orig = imem_mem[16];
        upd  = ~orig;
        n_vec++; if (bus.inst !== orig) begin n_err++; $display("FAIL smw_first: got %h want %h", bus.inst, orig); end
        step();
        imem_mem[16] = upd;
        n_vec++; if (bus.inst !== orig) begin n_err++; $display("FAIL smw_hold0: got %h want %h", bus.inst, orig); end
`ifdef FETCH_SKID_EN
        held = orig;
`else
        held = upd;
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (bus.inst !== held || bus.fetch_pc !== 32'h40) begin n_err++; $display("FAIL smw_hold: got %h@%h want %h@00000040", bus.inst, bus.fetch_pc, held); end
        end
        bus.stall = 1'b0;
        settle();
        n_vec++; if (bus.inst !== upd) begin n_err++; $display("FAIL smw_release: got %h want %h", bus.inst, upd); end
        step();
        n_vec++; if (bus.fetch_pc !== 32'h44 || bus.inst !== imem_mem[17]) begin n_err++; $display("FAIL smw_next: got %h@%h want %h@00000044", bus.inst, bus.fetch_pc, imem_mem[17]); end
    endtask

    task automatic test_reset_mid();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        settle();
        n_vec++; if (dbg_state !== BOOT || bus.fetch_pc !== RESET_PC) begin n_err++; $display("FAIL rmid_state: got %0d@%h want %0d@40000000", dbg_state, bus.fetch_pc, BOOT); end
        n_vec++; if (bus.inst_valid !== 1'b0 || bus.bios_addr !== 12'h000) begin n_err++; $display("FAIL rmid_out: got %b/%h want 0/000", bus.inst_valid, bus.bios_addr); end
        step();
        n_vec++; if (bus.inst !== 32'h93 || bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL rmid_boot: got %h/%b want 00000093/1", bus.inst, bus.inst_valid); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bios_mem[i] = $urandom;
        for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom;
        bios_mem[0] = 32'h0000_0093;
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_back_to_back();
        test_stall_mem_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
